ibex_data_axi4l_bridge: RTL
===========================

# ibex_data_axi4l_bridge

Single-outstanding bridge from the Ibex data-side request/grant interface to an AXI4-Lite master port. Sits directly upstream of `axi4l_dpramx32` and the other AXI4-Lite slaves. Converts each granted core access into one AXI4-Lite write (AW+W, then B) or read (AR, then R). Returns completion to the core as `data_rvalid_o`.

## Interface
- `ADDR_W`, default 32: core address width; must equal `addr_t` width.
- `aclk  input  1`: clock, same net as `axi.aclk`.
- `aresetn  input  1`: reset; **synchronous, active-low**.
- `data_req_i  input  1`: core request.
- `data_gnt_o  output  1`: request accepted this cycle.
- `data_we_i  input  1`: 1 = write, 0 = read.
- `data_be_i  input  4`: byte enables.
- `data_addr_i  input  ADDR_W`: byte address.
- `data_wdata_i  input  32`: write data.
- `data_rvalid_o  output  1`: single-cycle completion strobe.
- `data_rdata_o  output  32`: read data, valid with `data_rvalid_o`.
- `data_err_o  output  1`: error flag, valid with `data_rvalid_o`.
- `axi  axi4l_if.master  -`: AXI4-Lite master port.

## Operation
- FSM states: IDLE, WR (AW and/or W pending), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: `data_gnt_o = data_req_i && aresetn`, combinational. On grant, register addr/be/wdata/we.
  - we=1 → WR with `awvalid` = `wvalid` = 1.
  - we=0 → RD_ADDR with `arvalid` = 1.
- Address handling:
  - `awaddr`/`araddr` = registered address with bits [1:0] forced to 0.
  - `wstrb` = be; `wdata` = registered wdata.
  - `awprot` = `arprot` = 3'b000.
- WR: AW and W handshake independently. Each valid drops the cycle after its own handshake. Leave WR when both have completed, including same-cycle completion. → WR_RESP.
- WR_RESP: `bready` = 1. On B handshake → DONE, capture bresp.
- RD_ADDR: hold `arvalid` until `arready`. → RD_DATA.
- RD_DATA: `rready` = 1. On R handshake → DONE, capture rdata and rresp.
- DONE (one cycle):
  - `data_rvalid_o` = 1.
  - `data_rdata_o` = captured rdata on reads, 0 on writes.
  - `data_err_o` per Configuration.
  - `data_gnt_o` may assert in this same cycle, accepting the next request.
  - Next state: WR or RD_ADDR if granted, else IDLE.
- Valid hold: AW/W/AR valid and payload stay stable until their handshake; never withdrawn.
- At most one transaction in flight. Never more than one AW, one W and one AR outstanding.
- Reset:
  - All outputs reset to 0: valids, `bready`, `rready`, `data_rvalid_o`, `data_err_o`, `data_rdata_o`, `awaddr`, `araddr`, `wdata`, `wstrb`.
  - FSM resets to IDLE.
  - Reset mid-transaction abandons it; no `data_rvalid_o` is produced for it.

## Timing
- `data_gnt_o` is combinational. Every other output is registered.
- Write, ready slave (`awready` = `wready` = 1, B one cycle after W):
  - Grant in cycle 0.
  - AW/W valid in cycle 1.
  - `bvalid` in cycle 2.
  - `data_rvalid_o` in cycle 3.
- Read, same conditions: grant 0, AR 1, R 2, `data_rvalid_o` 3.
- Back-to-back throughput: one access per 3 cycles. The DONE cycle overlaps the next grant.
- Latency grows one cycle per ready/response stall cycle. No timeout.

## Configuration
- `IBEX_DATA_AXI4L_ERR_EN` defined:
  - `data_err_o` = 1 when the captured resp is SLVERR or DECERR.
  - On a read error, `data_rdata_o` is forced to 0.
- `IBEX_DATA_AXI4L_ERR_EN` undefined:
  - `data_err_o` tied to 0; resp is ignored.
  - `data_rdata_o` always = rdata.

## Structure
- `axi4l_pkg` holds:
  - `addr_t`, `data_t`, `strb_t`, `resp_t` (OKAY, EXOKAY, SLVERR, DECERR).
  - New constant `PROT_DATA_UNPRIV` = 3'b000.
- FSM state enum stays local to the module.
- No sub-module: one FSM plus payload registers.
- Formal harness reuses the existing AXI4-Lite outstanding-counter and stability properties, with master/slave assume/assert roles swapped.

## Test plan
- Write then read, against `axi4l_dpramx32` (size 'h10):
  - Write addr 0x4, be 4'hF, wdata 0xDEADBEEF → one AW/W/B, `data_rvalid_o` at cycle 3, err 0.
  - Read 0x4 → rdata 0xDEADBEEF.
- Partial write: write 0x8 = 0x11223344, then be 4'b0010 with wdata 0x0000AA00, then read 0x8 → 0x1122AA44.
- Skewed handshakes: `awready` delayed 3 cycles, `wready` immediate → `wvalid` drops after cycle 1, `awvalid` held with stable awaddr, exactly one B, one `data_rvalid_o`.
- Error, with `IBEX_DATA_AXI4L_ERR_EN`: slave returns SLVERR on a read of 0x0 → `data_err_o` = 1, `data_rdata_o` = 0. Without the macro → err 0.
- Back-to-back: `data_req_i` held high for 4 alternating write/read accesses → grants at cycles 0, 3, 6, 9 and four `data_rvalid_o` pulses.
- Reset mid-operation: `aresetn` low while in RD_DATA → next cycle all valids and readies are 0, no `data_rvalid_o`, and the first grant occurs on the first `data_req_i` after reset release.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types and constants for the data-side fabric.
package axi4l_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  typedef logic [AXI_ADDR_W-1:0]   addr_t;
  typedef logic [AXI_DATA_W-1:0]   data_t;
  typedef logic [AXI_DATA_W/8-1:0] strb_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  localparam logic [2:0] PROT_DATA_UNPRIV = 3'b000;

  // SLVERR and DECERR both carry bit 1 set.
  function automatic logic resp_is_err(input resp_t r);
    return r[1];
  endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle with master and slave views.
interface axi4l_if
  import axi4l_pkg::*;
(
  input logic aclk
);

  logic       awvalid;
  logic       awready;
  addr_t      awaddr;
  logic [2:0] awprot;
  logic       wvalid;
  logic       wready;
  data_t      wdata;
  strb_t      wstrb;
  logic       bvalid;
  logic       bready;
  resp_t      bresp;
  logic       arvalid;
  logic       arready;
  addr_t      araddr;
  logic [2:0] arprot;
  logic       rvalid;
  logic       rready;
  data_t      rdata;
  resp_t      rresp;

  modport master (
    input  aclk, awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready
  );

  modport slave (
    input  aclk, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/ibex_data_axi4l_bridge.sv
// Single-outstanding Ibex data req/gnt to AXI4-Lite master bridge.
// Define IBEX_DATA_AXI4L_ERR_EN to report SLVERR/DECERR on data_err_o.
module ibex_data_axi4l_bridge
  import axi4l_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  axi4l_if.master           axi
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t state;
  addr_t  word_addr;

  assign data_gnt_o  = data_req_i && aresetn && (state == IDLE || state == DONE);
  assign word_addr   = addr_t'({data_addr_i[ADDR_W-1:2], 2'b00});
  assign axi.awprot  = PROT_DATA_UNPRIV;
  assign axi.arprot  = PROT_DATA_UNPRIV;

  logic unused_sink;
  assign unused_sink = ^{axi.aclk, data_addr_i[1:0], axi.bresp, axi.rresp};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      axi.awvalid   <= 1'b0;
      axi.awaddr    <= '0;
      axi.wvalid    <= 1'b0;
      axi.wdata     <= '0;
      axi.wstrb     <= '0;
      axi.bready    <= 1'b0;
      axi.arvalid   <= 1'b0;
      axi.araddr    <= '0;
      axi.rready    <= 1'b0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else begin
      data_rvalid_o <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (data_gnt_o) begin
            if (data_we_i) begin
              state       <= WR;
              axi.awvalid <= 1'b1;
              axi.awaddr  <= word_addr;
              axi.wvalid  <= 1'b1;
              axi.wdata   <= data_wdata_i;
              axi.wstrb   <= data_be_i;
            end else begin
              state       <= RD_ADDR;
              axi.arvalid <= 1'b1;
              axi.araddr  <= word_addr;
            end
          end else begin
            state <= IDLE;
          end
        end
        WR: begin
          // AW and W retire independently; leave once neither is still pending.
          if (axi.awvalid && axi.awready) axi.awvalid <= 1'b0;
          if (axi.wvalid && axi.wready)   axi.wvalid  <= 1'b0;
          if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
            state      <= WR_RESP;
            axi.bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            state         <= DONE;
            axi.bready    <= 1'b0;
            data_rvalid_o <= 1'b1;
            data_rdata_o  <= '0;
`ifdef IBEX_DATA_AXI4L_ERR_EN
            data_err_o    <= resp_is_err(axi.bresp);
`else
            data_err_o    <= 1'b0;
`endif
          end
        end
        RD_ADDR: begin
          if (axi.arready) begin
            state       <= RD_DATA;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            state         <= DONE;
            axi.rready    <= 1'b0;
            data_rvalid_o <= 1'b1;
`ifdef IBEX_DATA_AXI4L_ERR_EN
            data_err_o    <= resp_is_err(axi.rresp);
            data_rdata_o  <= resp_is_err(axi.rresp) ? '0 : axi.rdata;
`else
            data_err_o    <= 1'b0;
            data_rdata_o  <= axi.rdata;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
